// File: rtl/module_alu_pkg.sv
// rtl/module_alu_pkg.sv - ALU opcodes and sequencer state encoding
package module_alu_pkg;

    localparam logic [3:0] OP_AND = 4'hD;
    localparam logic [3:0] OP_OR  = 4'hE;
    localparam logic [3:0] OP_ADD = 4'hB;
    localparam logic [3:0] OP_SUB = 4'hC;
    localparam logic [3:0] OP_SHL = 4'hF;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL_ADD,
        ST_MUL_SHIFT,
        ST_DONE
    } state_t;

    // Native ALU ops occupy the contiguous range 0xB..0xF.
    function automatic logic is_native_op(input logic [3:0] op);
        return (op >= OP_ADD);
    endfunction

endpackage

// File: rtl/module_alu_sequencer.sv
// rtl/module_alu_sequencer.sv - command sequencer in front of an external combinational ALU
module module_alu_sequencer
    import module_alu_pkg::*;
#(
    parameter int         WIDTH  = 16,
    parameter logic [3:0] MUL_OP = 4'hA
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_err_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_result_i
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] m, m_d;
    logic [WIDTH-1:0] q, q_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] res_data_d;
    logic             res_err_d;
    logic [WIDTH-1:0] alu_a_d, alu_b_d;
    logic [3:0]       alu_ctrl_d;

    assign cmd_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign res_valid_o = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath registers; ALU drive is registered so it is set up one state ahead.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q       <= '0;
            acc        <= '0;
            m          <= '0;
            q          <= '0;
            cnt        <= '0;
            res_data_o <= '0;
            res_err_o  <= 1'b0;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            alu_ctrl_o <= '0;
        end else begin
            op_q       <= op_d;
            acc        <= acc_d;
            m          <= m_d;
            q          <= q_d;
            cnt        <= cnt_d;
            res_data_o <= res_data_d;
            res_err_o  <= res_err_d;
            alu_a_o    <= alu_a_d;
            alu_b_o    <= alu_b_d;
            alu_ctrl_o <= alu_ctrl_d;
        end
    end

    // Next-state and next-datapath logic; ALU is idle (all zero) unless a state below drives it.
    always_comb begin
        state_d    = state;
        op_d       = op_q;
        acc_d      = acc;
        m_d        = m;
        q_d        = q;
        cnt_d      = cnt;
        res_data_d = res_data_o;
        res_err_d  = res_err_o;
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_ctrl_d = '0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d = cmd_op_i;
                    if (cmd_op_i == MUL_OP) begin
                        state_d    = ST_MUL_ADD;
                        acc_d      = '0;
                        m_d        = cmd_a_i;
                        q_d        = cmd_b_i;
                        cnt_d      = '0;
                        alu_ctrl_d = OP_ADD;
                        alu_a_d    = '0;
                        alu_b_d    = cmd_b_i[0] ? cmd_a_i : '0;
                    end else begin
                        state_d    = ST_EXEC;
                        alu_ctrl_d = cmd_op_i;
                        alu_a_d    = cmd_a_i;
                        alu_b_d    = cmd_b_i;
                    end
                end
            end

            ST_EXEC: begin
                // Illegal ops reach the ALU too; its default arm returns zero.
                res_data_d = alu_result_i;
                res_err_d  = !is_native_op(op_q);
                state_d    = ST_DONE;
            end

            ST_MUL_ADD: begin
                acc_d      = alu_result_i;
                state_d    = ST_MUL_SHIFT;
                alu_ctrl_d = OP_SHL;
                alu_a_d    = m;
                alu_b_d    = ONE;
            end

            ST_MUL_SHIFT: begin
                m_d   = alu_result_i;
                q_d   = q >> 1;
                cnt_d = cnt + CNT_W'(1);
                if ((q_d == '0) || (cnt == CNT_LAST)) begin
                    res_data_d = acc;
                    res_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    // Next partial product uses the freshly shifted multiplicand.
                    state_d    = ST_MUL_ADD;
                    alu_ctrl_d = OP_ADD;
                    alu_a_d    = acc;
                    alu_b_d    = q_d[0] ? alu_result_i : '0;
                end
            end

            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_module_alu_sequencer.sv
// tb/tb_module_alu_sequencer.sv - self-checking bench for module_alu_sequencer with a behavioural ALU
module tb_module_alu_sequencer;
    import module_alu_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_result;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    module_alu_sequencer #(.WIDTH(16), .MUL_OP(4'hA)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_err_o    (res_err),
        .busy_o       (busy),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result)
    );

    // Stand-in for the existing combinational ALU.
    always_comb begin
        case (alu_ctrl)
            4'hD:    alu_result = alu_a & alu_b;
            4'hE:    alu_result = alu_a | alu_b;
            4'hB:    alu_result = alu_a + alu_b;
            4'hC:    alu_result = alu_a - alu_b;
            4'hF:    alu_result = (alu_b >= 16) ? 16'h0 : (alu_a << alu_b[3:0]);
            default: alu_result = 16'h0;
        endcase
    end

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [31:0] p;
        int k;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            4'hD: e.data = a & b;
            4'hE: e.data = a | b;
            4'hB: e.data = a + b;
            4'hC: e.data = a - b;
            4'hF: e.data = (b >= 16) ? 16'h0 : (a << b[3:0]);
            4'hA: begin
                p = a * b;
                e.data = p[15:0];
                k = 1;
                for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
                e.lat = 2 * k;
            end
            default: begin
                e.data = 16'h0;
                e.err  = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Offer a command, wait for acceptance, then count cycles until the result shows up.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] d, output logic er, output int lat, output logic ok);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = res_data;
        er = res_err;
        ok = res_valid;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 4'($urandom);
            cmd_a     = 16'($urandom);
            cmd_b     = 16'($urandom);
            res_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++; if (res_valid !== 1'b0)   begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if (res_data !== 16'h0)   begin errors++; $display("FAIL reset_res_data got %h want 0000", res_data); end
        checks++; if (res_err !== 1'b0)     begin errors++; $display("FAIL reset_res_err got %b want 0", res_err); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1)   begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (alu_a !== 16'h0)      begin errors++; $display("FAIL reset_alu_a got %h want 0000", alu_a); end
        checks++; if (alu_b !== 16'h0)      begin errors++; $display("FAIL reset_alu_b got %h want 0000", alu_b); end
        checks++; if (alu_ctrl !== 4'h0)    begin errors++; $display("FAIL reset_alu_ctrl got %h want 0", alu_ctrl); end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        logic [3:0]  ops[2] = '{OP_ADD, OP_SUB};
        logic [15:0] as[2]  = '{16'h1234, 16'h0003};
        logic [15:0] bs[2]  = '{16'h0FFF, 16'h0005};
        logic [15:0] ws[2]  = '{16'h2233, 16'hFFFE};
        logic [15:0] d; logic er; int lat; logic ok; exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{data: ws[i], err: 1'b0, lat: 1});
            do_cmd(ops[i], as[i], bs[i], d, er, lat, ok);
            e = sb.pop_front();
            checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL add_sub_data[%0d] got %h want %h", i, d, e.data); end
            checks++; if (er !== e.err)        begin errors++; $display("FAIL add_sub_err[%0d] got %b want %b", i, er, e.err); end
            checks++; if (lat !== e.lat)       begin errors++; $display("FAIL add_sub_latency[%0d] got %0d want %0d", i, lat, e.lat); end
            consume();
        end
    endtask

    task automatic test_mul();
        logic [15:0] as[8] = '{16'h0013, 16'h1234, 16'hFFFF, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] bs[8] = '{16'h0007, 16'h0000, 16'hFFFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
        int          ls[4] = '{6, 2, 32, 32};
        logic [15:0] ds[4] = '{16'h0085, 16'h0000, 16'h0001, 16'h0000};
        logic [15:0] d; logic er; int lat; logic ok; exp_t e;
        for (int i = 4; i < 8; i++) begin
            as[i] = 16'($urandom);
            bs[i] = 16'($urandom) >> $urandom_range(0, 15);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 4) sb.push_back('{data: ds[i], err: 1'b0, lat: ls[i]});
            else       sb.push_back(model(OP_MUL, as[i], bs[i]));
            do_cmd(OP_MUL, as[i], bs[i], d, er, lat, ok);
            e = sb.pop_front();
            checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL mul_data %h*%h got %h want %h", as[i], bs[i], d, e.data); end
            checks++; if (er !== 1'b0)         begin errors++; $display("FAIL mul_err %h*%h got %b want 0", as[i], bs[i], er); end
            checks++; if (lat !== e.lat)       begin errors++; $display("FAIL mul_latency %h*%h got %0d want %0d", as[i], bs[i], lat, e.lat); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d; logic er; int lat; logic ok; exp_t e;
        sb.push_back('{data: 16'h0010, err: 1'b0, lat: 1});
        do_cmd(OP_SHL, 16'h0001, 16'h0004, d, er, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, e.lat); end
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 16'h1111;
        cmd_b     = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (res_data !== e.data) begin errors++; $display("FAIL bp_data_stable[%0d] got %h want %h", i, res_data, e.data); end
            checks++; if (res_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid_held[%0d] got %b want 1", i, res_valid); end
            checks++; if (cmd_ready !== 1'b0)  begin errors++; $display("FAIL bp_cmd_ready[%0d] got %b want 0", i, cmd_ready); end
        end
        cmd_valid = 1'b0;
        consume();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", res_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL bp_offered_cmd_taken busy got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL bp_idle_after got %b want 0", busy); end
    endtask

    task automatic test_illegal();
        logic [15:0] d; logic er; int lat; logic ok; exp_t e;
        sb.push_back(model(4'h3, 16'hFFFF, 16'hFFFF));
        do_cmd(4'h3, 16'hFFFF, 16'hFFFF, d, er, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || d !== 16'h0000) begin errors++; $display("FAIL illegal_data got %h want 0000", d); end
        checks++; if (er !== 1'b1)           begin errors++; $display("FAIL illegal_err got %b want 1", er); end
        checks++; if (lat !== e.lat)         begin errors++; $display("FAIL illegal_latency got %0d want %0d", lat, e.lat); end
        consume();
        sb.push_back(model(OP_OR, 16'h00F0, 16'h0F00));
        do_cmd(OP_OR, 16'h00F0, 16'h0F00, d, er, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL after_illegal_data got %h want %h", d, e.data); end
        checks++; if (er !== 1'b0)         begin errors++; $display("FAIL after_illegal_err got %b want 0", er); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL, OP_SHL};
        logic [15:0] a, b, d; logic er; int lat; logic ok; exp_t e;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom);
            b = (i == 5) ? 16'd16 + 16'($urandom_range(0, 100)) : 16'($urandom);
            if (i == 4) b = 16'($urandom_range(0, 15));
            sb.push_back(model(ops[i], a, b));
            do_cmd(ops[i], a, b, d, er, lat, ok);
            e = sb.pop_front();
            checks++; if (!ok || d !== e.data) begin errors++; $display("FAIL b2b_data op %h a %h b %h got %h want %h", ops[i], a, b, d, e.data); end
            checks++; if (er !== e.err || lat !== e.lat) begin errors++; $display("FAIL b2b_err_lat op %h got %b/%0d want %b/%0d", ops[i], er, lat, e.err, e.lat); end
            consume();
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [15:0] d; logic er; int lat; logic ok; exp_t e;
        int seen = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_a     = 16'hFFFF;
        cmd_b     = 16'hFFFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle busy %b ready %b want 0 1", busy, cmd_ready); end
        checks++; if (res_data !== 16'h0 || alu_ctrl !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0)
            begin errors++; $display("FAIL mid_reset_regs data %h ctrl %h a %h b %h want zeros", res_data, alu_ctrl, alu_a, alu_b); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_result valid seen %0d times want 0", seen); end
        sb.push_back(model(OP_MUL, 16'h0003, 16'h0005));
        do_cmd(OP_MUL, 16'h0003, 16'h0005, d, er, lat, ok);
        e = sb.pop_front();
        checks++; if (!ok || d !== e.data || lat !== e.lat) begin errors++; $display("FAIL post_reset_mul got %h/%0d want %h/%0d", d, lat, e.data, e.lat); end
        consume();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        res_ready = 1'b0;
        test_reset();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
